// File: rtl/ttc_pkg21.sv
// -----------------------------------------------------------------------------
// ttc_pkg21
//
// Shared definitions for the TTC clock prescaler slice.
//
// Contents:
//   CLK_CTRL_*  bit positions inside the 7-bit clock-control value
//   CNT_W_DEF   default prescale counter width
//   ps_mask()   terminal-count mask for prescale value P
//
// Optional feature macro used by the users of this package: TTC_EXT_CLK_EN
// -----------------------------------------------------------------------------
package ttc_pkg21;

    // Clock-control field positions.
    localparam int CLK_CTRL_PS_EN    = 0;
    localparam int CLK_CTRL_PS_LSB   = 1;
    localparam int CLK_CTRL_PS_MSB   = 4;
    localparam int CLK_CTRL_EXT_SEL  = 5;
    localparam int CLK_CTRL_EXT_EDGE = 6;

    // Width of the clock-control value.
    localparam int CLK_CTRL_W = 7;

    // 16 bits are enough for the largest mask (P = 15 -> 16'hFFFF).
    localparam int CNT_W_DEF = 16;

    // Terminal-count mask 2^(P+1)-1. The counter ticks when all mask bits
    // are set, giving a divide ratio of 2^(P+1). Returned at 32 bits so the
    // caller can narrow it to its own counter width.
    function automatic logic [31:0] ps_mask(input logic [3:0] p);
        logic [4:0] sh;
        sh      = {1'b0, p} + 5'd1;
        ps_mask = (32'd1 << sh) - 32'd1;
    endfunction

endpackage : ttc_pkg21

// File: rtl/ttc_ext_edge_sync21.sv
// -----------------------------------------------------------------------------
// ttc_ext_edge_sync21
//
// Brings the asynchronous external clock into the pclk domain and turns the
// selected edge into a one-cycle event.
//
// Ports:
//   pclk_i      in   system clock, rising edge
//   rst_i       in   synchronous active-high reset
//   ext_clk_i   in   asynchronous external clock
//   edge_fall_i in   0 = report rising edges, 1 = report falling edges
//   evt_ext_o   out  one-cycle event on the selected synchronised edge
//
// Only built when TTC_EXT_CLK_EN is defined (see the top level).
// -----------------------------------------------------------------------------
module ttc_ext_edge_sync21 (
    input  logic pclk_i,
    input  logic rst_i,
    input  logic ext_clk_i,
    input  logic edge_fall_i,
    output logic evt_ext_o
);

    // s1_q/s2_q form the metastability synchroniser; h_q remembers the
    // previous synchronised level so edges can be detected.
    logic s1_q, s2_q, h_q;
    logic s1_d, s2_d, h_d;

    always_comb begin
        s1_d = ext_clk_i;
        s2_d = s1_q;
        h_d  = s2_q;
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            h_q  <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            h_q  <= h_d;
        end
    end

    // Since h_q is cleared by reset, an external clock that is already high
    // at reset release produces one rising-edge event. That is intended.
    always_comb begin
        if (edge_fall_i) begin
            evt_ext_o = ~s2_q & h_q;
        end else begin
            evt_ext_o = s2_q & ~h_q;
        end
    end

endmodule : ttc_ext_edge_sync21

// File: rtl/ttc_clk_prescale_lite21.sv
// -----------------------------------------------------------------------------
// ttc_clk_prescale_lite21
//
// Turns the TTC clock-control value and counter enable into a registered
// one-cycle count tick for the timer counter. The tick source is every pclk
// cycle or, optionally, a synchronised external clock edge; an optional
// power-of-two prescaler divides the source by 2^(P+1).
//
// Parameters:
//   CNT_W              prescale counter width (>= 16)
//
// Ports:
//   pclk21             in   system clock, all logic on its rising edge
//   p_reset21          in   synchronous active-high reset
//   clk_ctrl_reg_in21  in   [0] prescale enable, [4:1] prescale value P,
//                           [5] external source select,
//                           [6] external edge (0 rising, 1 falling)
//   count_en_in21      in   counter enable; low restarts the prescaler
//   ext_clk21          in   asynchronous external clock
//   count_tick21       out  registered one-cycle tick to the counter
//   prescale_cnt21     out  current prescale count (read-back)
//
// Build option:
//   TTC_EXT_CLK_EN     when defined, bit [5] selects the external clock edge
//                      as the event source. When undefined, every pclk cycle
//                      is an event and ext_clk21 is not used.
// -----------------------------------------------------------------------------
module ttc_clk_prescale_lite21
    import ttc_pkg21::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  pclk21,
    input  logic                  p_reset21,
    input  logic [CLK_CTRL_W-1:0] clk_ctrl_reg_in21,
    input  logic                  count_en_in21,
    input  logic                  ext_clk21,
    output logic                  count_tick21,
    output logic [CNT_W-1:0]      prescale_cnt21
);

    logic [CLK_CTRL_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick_q, tick_d;

    logic [CNT_W-1:0]      mask;
    logic [3:0]            ps_val;
    logic                  cfg_change;
    logic                  at_terminal;
    logic                  evt;

    // ------------------------------------------------------------------
    // Event source
    // ------------------------------------------------------------------
`ifdef TTC_EXT_CLK_EN
    logic evt_ext;

    ttc_ext_edge_sync21 u_ext_sync (
        .pclk_i      (pclk21),
        .rst_i       (p_reset21),
        .ext_clk_i   (ext_clk21),
        .edge_fall_i (cfg_q[CLK_CTRL_EXT_EDGE]),
        .evt_ext_o   (evt_ext)
    );

    assign evt = cfg_q[CLK_CTRL_EXT_SEL] ? evt_ext : 1'b1;
`else
    // External source not built: pclk is the only source.
    logic unused_ext_clk;
    assign unused_ext_clk = ext_clk21;
    assign evt            = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Prescale mask
    // ------------------------------------------------------------------
    // The mask comes from the registered configuration. In any cycle where
    // it could matter the input equals cfg_q, because a differing input is a
    // change cycle that clears the count regardless.
    assign ps_val = cfg_q[CLK_CTRL_PS_MSB:CLK_CTRL_PS_LSB];
    assign mask   = cfg_q[CLK_CTRL_PS_EN] ? CNT_W'(ps_mask(ps_val)) : '0;

    assign cfg_change  = (clk_ctrl_reg_in21 != cfg_q);
    assign at_terminal = ((cnt_q & mask) == mask);

    // ------------------------------------------------------------------
    // Next-state logic, in priority order
    // ------------------------------------------------------------------
    always_comb begin
        cfg_d  = clk_ctrl_reg_in21;  // tracked every cycle, even when disabled
        cnt_d  = cnt_q;
        tick_d = 1'b0;

        if (!count_en_in21) begin
            // Disabling for any length of time restarts a full period.
            cnt_d = '0;
        end else if (cfg_change) begin
            // Clearing here keeps a stale high count from outliving a
            // smaller P; no tick is issued in the change cycle.
            cnt_d = '0;
        end else if (evt && at_terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else if (evt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk21) begin
        if (p_reset21) begin
            cfg_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign count_tick21   = tick_q;
    assign prescale_cnt21 = cnt_q;

endmodule : ttc_clk_prescale_lite21

// File: tb/tb_ttc_clk_prescale_lite21.sv
// -----------------------------------------------------------------------------
// tb_ttc_clk_prescale_lite21
//
// Reference model: counts source events since the last restart and ticks when
// that count reaches the divide ratio 2^(P+1) (or 1 with the prescaler off).
// External edges come from a short history of sampled ext_clk21 levels.
// Expected {tick, count} pairs are queued at each rising edge and compared by
// a separate monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_ttc_clk_prescale_lite21;

    localparam int CNT_W = 16;

`ifdef TTC_EXT_CLK_EN
    localparam bit EXT_ON = 1'b1;
`else
    localparam bit EXT_ON = 1'b0;
`endif

    logic             pclk21 = 1'b0;
    logic             p_reset21;
    logic [6:0]       clk_ctrl_reg_in21;
    logic             count_en_in21;
    logic             ext_clk21;
    logic             count_tick21;
    logic [CNT_W-1:0] prescale_cnt21;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 pclk21 = ~pclk21;

    ttc_clk_prescale_lite21 #(.CNT_W(CNT_W)) dut (
        .pclk21            (pclk21),
        .p_reset21         (p_reset21),
        .clk_ctrl_reg_in21 (clk_ctrl_reg_in21),
        .count_en_in21     (count_en_in21),
        .ext_clk21         (ext_clk21),
        .count_tick21      (count_tick21),
        .prescale_cnt21    (prescale_cnt21)
    );

    // ---------------- reference model ----------------
    logic [CNT_W:0] exp_q[$];   // {tick, count}
    logic [6:0]     m_cfg;
    int             m_events;
    logic [2:0]     m_ext;      // [0] newest sampled ext level, [2] oldest

    always @(posedge pclk21) begin : ref_model
        logic evt;
        logic m_tick;
        int   ratio;
        m_tick = 1'b0;
        if (p_reset21) begin
            m_cfg    = '0;
            m_events = 0;
            m_ext    = '0;
        end else begin
            // The level seen as "current" is two samples old, "previous" three.
            if (EXT_ON && m_cfg[5])
                evt = m_cfg[6] ? (!m_ext[1] && m_ext[2]) : (m_ext[1] && !m_ext[2]);
            else
                evt = 1'b1;
            ratio = m_cfg[0] ? (1 << (int'(m_cfg[4:1]) + 1)) : 1;
            if (!count_en_in21 || clk_ctrl_reg_in21 != m_cfg) begin
                m_events = 0;
            end else if (evt) begin
                m_events++;
                if (m_events == ratio) begin
                    m_tick   = 1'b1;
                    m_events = 0;
                end
            end
            m_cfg = clk_ctrl_reg_in21;
            m_ext = {m_ext[1:0], ext_clk21};
        end
        exp_q.push_back({m_tick, CNT_W'(m_events)});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge pclk21) begin : monitor
        logic [CNT_W:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (count_tick21 !== e[CNT_W]) begin
                n_fail++;
                $display("FAIL tick @%0t: got %b expected %b", $time, count_tick21, e[CNT_W]);
            end
            n_tests++;
            if (prescale_cnt21 !== e[CNT_W-1:0]) begin
                n_fail++;
                $display("FAIL count @%0t: got %0d expected %0d", $time, prescale_cnt21, e[CNT_W-1:0]);
            end
        end
    end

    // ---------------- driver ----------------
    int ext_half = 0;   // 0 = ext_clk21 static, else half period in pclk cycles
    int ext_ph   = 0;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk21);
            if (ext_half > 0) begin
                ext_ph++;
                if (ext_ph >= ext_half) begin
                    ext_ph    = 0;
                    ext_clk21 = ~ext_clk21;
                end
            end
        end
    endtask

    function automatic logic [6:0] rand_cfg();
        return {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'b00, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
    endfunction

    initial begin
        p_reset21         = 1'b1;
        count_en_in21     = 1'b0;
        clk_ctrl_reg_in21 = '0;
        ext_clk21         = 1'b0;

        // Reset with the other inputs toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk21);
            count_en_in21     = 1'($urandom_range(0, 1));
            clk_ctrl_reg_in21 = 7'($urandom_range(0, 127));
            ext_clk21         = 1'($urandom_range(0, 1));
        end
        @(negedge pclk21);
        p_reset21         = 1'b0;
        clk_ctrl_reg_in21 = 7'h00;
        count_en_in21     = 1'b1;
        ext_clk21         = 1'b0;

        // Divide-by-one.
        step(12);

        // Prescale P=2, then P=0 mid-period.
        clk_ctrl_reg_in21 = 7'h05;
        step(29);
        clk_ctrl_reg_in21 = 7'h01;
        step(10);

        // Restart at cnt=9 with P=3.
        clk_ctrl_reg_in21 = 7'h07;
        step(10);
        count_en_in21 = 1'b0;
        step(1);
        count_en_in21 = 1'b1;
        step(40);

        // External falling edge, ext period 8 pclk.
        clk_ctrl_reg_in21 = 7'h60;
        ext_half          = 4;
        step(50);

        // Source select with static ext clock.
        ext_half          = 0;
        clk_ctrl_reg_in21 = 7'h20;
        step(10);

        // Randomised segments.
        for (int s = 0; s < 14; s++) begin
            int len;
            clk_ctrl_reg_in21 = rand_cfg();
            ext_half          = int'($urandom_range(2, 5));
            len               = int'($urandom_range(20, 60));
            for (int c = 0; c < len; c++) begin
                count_en_in21 = ($urandom_range(0, 15) != 0);
                step(1);
            end
            if (s == 7) begin
                p_reset21 = 1'b1;
                step(2);
                p_reset21 = 1'b0;
            end
        end
        count_en_in21 = 1'b1;
        step(3);
        #1;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ttc_clk_prescale_lite21
